// File: rtl/lfsr_rand_gen.sv
// Galois-LFSR random source with seed load, single-step, prescaled free-run, draw handshake and hex readout.
// Latency: step/tick advance in 1 cycle; a draw returns rnd_valid DRAW_STEPS+1 cycles after req; seg lags lfsr_q by 1.
// Backpressure: none; req is ignored while busy and rnd_valid is a single-cycle pulse with no ready.
module lfsr_rand_gen #(
    parameter int                 WIDTH      = 8,
    parameter logic [WIDTH-1:0]   TAPS       = 8'h8E,
    parameter logic [WIDTH-1:0]   ZERO_FILL  = 8'hAA,
    parameter int                 DIV        = 4,
    parameter int                 DRAW_STEPS = 3,
    localparam int                NDIG       = WIDTH / 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      seed,
    input  logic                  run,
    input  logic                  step,
    input  logic                  req,
    output logic                  busy,
    output logic                  rnd_valid,
    output logic [WIDTH-1:0]      rnd,
    output logic [WIDTH-1:0]      lfsr_q,
    output logic [7*NDIG-1:0]     seg
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DRAW_STEPS > 1) ? $clog2(DRAW_STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DRAW = 2'd2;

    logic [1:0]        state;
    logic [PW-1:0]     presc;
    logic [DW-1:0]     dcnt;
    logic [WIDTH-1:0]  nxt;
    logic              tick;
    logic              draw_last;
    logic [7*NDIG-1:0] seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // All-zero is the LFSR lock-up state, so it is replaced by ZERO_FILL instead of shifting.
    always_comb begin
        nxt = '0;
        if (lfsr_q == '0)
            nxt = ZERO_FILL;
        else
            nxt = (lfsr_q >> 1) ^ ({WIDTH{lfsr_q[0]}} & TAPS);
    end

    assign tick      = (state == RUN) && (presc == PW'(DIV - 1));
    assign draw_last = (dcnt == DW'(DRAW_STEPS - 1));
    assign busy      = (state == DRAW);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            dcnt      <= '0;
            lfsr_q    <= '0;
            rnd       <= '0;
            rnd_valid <= 1'b0;
        end else begin
            rnd_valid <= 1'b0;
            if (load) begin
                // Load also aborts a draw in flight and swallows any coincident req.
                lfsr_q <= seed;
                presc  <= '0;
                dcnt   <= '0;
                state  <= run ? RUN : IDLE;
            end else if (state == DRAW) begin
                lfsr_q <= nxt;
                dcnt   <= dcnt + DW'(1);
                if (draw_last) begin
                    rnd       <= nxt;
                    rnd_valid <= 1'b1;
                    dcnt      <= '0;
                    presc     <= '0;
                    state     <= run ? RUN : IDLE;
                end
            end else begin
                if (step || tick)
                    lfsr_q <= nxt;
                if (state == RUN)
                    presc <= tick ? '0 : presc + PW'(1);
                if (req) begin
                    dcnt  <= '0;
                    state <= DRAW;
                end else if (state == IDLE && run) begin
                    presc <= '0;
                    state <= RUN;
                end else if (state == RUN && !run) begin
                    state <= IDLE;
                end
            end
        end
    end

    always_comb begin
        seg_nxt = '0;
        for (int k = 0; k < NDIG; k++)
            seg_nxt[7*k +: 7] = hex7(lfsr_q[4*k +: 4]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NDIG; k++)
                seg[7*k +: 7] <= 7'b1000000;
        end else begin
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen with default parameters (8-bit, taps 8E, fill AA, DIV 4, 3-step draw).
module tb_lfsr_rand_gen;

    logic        clk = 1'b0;
    logic        reset, load, run, step, req;
    logic [7:0]  seed;
    logic        busy, rnd_valid;
    logic [7:0]  rnd, lfsr_q;
    logic [13:0] seg;

    int errors = 0;
    int checks = 0;

    lfsr_rand_gen dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .run       (run),
        .step      (step),
        .req       (req),
        .busy      (busy),
        .rnd_valid (rnd_valid),
        .rnd       (rnd),
        .lfsr_q    (lfsr_q),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int ones_seen;
        int zeros_seen;
        reset = 1'b1; load = 1'b0; run = 1'b0; step = 1'b0; req = 1'b0; seed = 8'h00;
        edge1();
        edge1();
        reset = 1'b0;
        chk("rst_lfsr", 32'(lfsr_q), 32'h00);
        chk("rst_rnd", 32'(rnd), 32'h00);
        chk("rst_valid", 32'(rnd_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_seg", 32'(seg), 32'h2040);

        // Zero state escapes to the fill value, display follows one cycle later.
        step = 1'b1;
        edge1();
        step = 1'b0;
        chk("zero_fill", 32'(lfsr_q), 32'hAA);
        chk("seg_lag", 32'(seg), 32'h2040);
        edge1();
        chk("seg_AA", 32'(seg), 32'h0408);

        // Seed then single steps.
        load = 1'b1; seed = 8'h01;
        edge1();
        load = 1'b0;
        chk("load_01", 32'(lfsr_q), 32'h01);
        step = 1'b1;
        edge1();
        chk("step1", 32'(lfsr_q), 32'h8E);
        edge1();
        chk("step2", 32'(lfsr_q), 32'h47);
        edge1();
        chk("step3", 32'(lfsr_q), 32'hAD);
        step = 1'b0;
        edge1();
        chk("seg_AD", 32'(seg), 32'h0421);

        // Draw: busy for 3 cycles, then one rnd_valid pulse. step held high must be ignored.
        load = 1'b1; seed = 8'h01;
        edge1();
        load = 1'b0;
        req = 1'b1;
        edge1();
        req = 1'b0; step = 1'b1;
        chk("draw_busy1", 32'(busy), 32'h1);
        chk("draw_nv1", 32'(rnd_valid), 32'h0);
        edge1();
        chk("draw_busy2", 32'(busy), 32'h1);
        chk("draw_l1", 32'(lfsr_q), 32'h8E);
        edge1();
        chk("draw_busy3", 32'(busy), 32'h1);
        chk("draw_l2", 32'(lfsr_q), 32'h47);
        edge1();
        step = 1'b0;
        chk("draw_done_busy", 32'(busy), 32'h0);
        chk("draw_valid", 32'(rnd_valid), 32'h1);
        chk("draw_rnd", 32'(rnd), 32'hAD);
        edge1();
        chk("draw_pulse_end", 32'(rnd_valid), 32'h0);
        chk("draw_rnd_hold", 32'(rnd), 32'hAD);

        // Load in second draw cycle aborts the draw.
        load = 1'b1; seed = 8'h01;
        edge1();
        load = 1'b0;
        req = 1'b1;
        edge1();
        req = 1'b0;
        edge1();
        chk("abort_in_draw", 32'(busy), 32'h1);
        load = 1'b1; seed = 8'h5A;
        edge1();
        load = 1'b0;
        chk("abort_lfsr", 32'(lfsr_q), 32'h5A);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_valid", 32'(rnd_valid), 32'h0);
        edge1();
        edge1();
        chk("abort_no_valid", 32'(rnd_valid), 32'h0);
        chk("abort_rnd", 32'(rnd), 32'hAD);

        // req coincident with load is dropped.
        load = 1'b1; req = 1'b1; seed = 8'h01;
        edge1();
        load = 1'b0; req = 1'b0;
        chk("ldreq_busy", 32'(busy), 32'h0);
        chk("ldreq_lfsr", 32'(lfsr_q), 32'h01);

        // Seed of zero is accepted and left on the next advance.
        load = 1'b1; seed = 8'h00;
        edge1();
        load = 1'b0;
        chk("seed0", 32'(lfsr_q), 32'h00);
        step = 1'b1;
        edge1();
        step = 1'b0;
        chk("seed0_step", 32'(lfsr_q), 32'hAA);

        // Free-run at DIV=4: loading with run high enters RUN with a cleared prescaler.
        load = 1'b1; seed = 8'h01; run = 1'b1;
        edge1();
        load = 1'b0;
        edge1();
        edge1();
        edge1();
        chk("run_c3", 32'(lfsr_q), 32'h01);
        edge1();
        chk("run_c4", 32'(lfsr_q), 32'h8E);
        edge1();
        edge1();
        edge1();
        chk("run_c7", 32'(lfsr_q), 32'h8E);
        edge1();
        chk("run_c8", 32'(lfsr_q), 32'h47);

        // Full period: 255 advances return to 01 without visiting 00 or 01 in between.
        load = 1'b1; seed = 8'h01;
        edge1();
        load = 1'b0;
        ones_seen = 0;
        zeros_seen = 0;
        for (int c = 1; c <= 255 * 4; c++) begin
            edge1();
            if (lfsr_q == 8'h00) zeros_seen++;
            if (c % 4 == 0 && c < 255 * 4 && lfsr_q == 8'h01) ones_seen++;
        end
        run = 1'b0;
        chk("period_end", 32'(lfsr_q), 32'h01);
        chk("period_no_zero", 32'(zeros_seen), 32'h0);
        chk("period_no_early", 32'(ones_seen), 32'h0);

        edge1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
